// File: rtl/transmitter.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 even-parity bit and
// 1 stop bit (2 stop bits when TX_TWO_STOP_EN is defined). The baud divider
// table and the baud_select encoding are the same as the paired receiver's.
// Each bit lasts OVERSAMPLE baud ticks. Data and baud code are latched when a
// frame is accepted, so later changes on the inputs do not affect that frame.
//
// Optional feature macro: TX_TWO_STOP_EN (adds a second stop bit period).
//
// Host handshake: a write is accepted on a rising edge where the FSM is IDLE
// and Tx_EN and Tx_WR are both high. Tx_BUSY is high from the accepting edge
// until the edge that ends the last stop bit. On that edge Tx_DONE pulses for
// one cycle. Writes made while Tx_BUSY is high or Tx_EN is low are dropped
// without side effects. A write in the Tx_DONE cycle starts the next frame
// right after the stop bit.
`timescale 1ns/1ps

module transmitter #(
    parameter int CLK_HZ     = 100000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Clock cycles per baud tick, rounded to nearest, minus one (wrap value).
    function automatic logic [14:0] div_limit(input int baud);
        int d;
        d = (CLK_HZ + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
        return 15'(d - 1);
    endfunction

    localparam logic [14:0] LIM_300    = div_limit(300);
    localparam logic [14:0] LIM_1200   = div_limit(1200);
    localparam logic [14:0] LIM_4800   = div_limit(4800);
    localparam logic [14:0] LIM_9600   = div_limit(9600);
    localparam logic [14:0] LIM_19200  = div_limit(19200);
    localparam logic [14:0] LIM_38400  = div_limit(38400);
    localparam logic [14:0] LIM_57600  = div_limit(57600);
    localparam logic [14:0] LIM_115200 = div_limit(115200);

    localparam int            TW        = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    state_t          state_q;
    logic [14:0]     div_q;
    logic [14:0]     div_d;
    logic [TW-1:0]   tick_q;
    logic [TW-1:0]   tick_d;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [2:0]      baud_q;
    logic            txd_q;
    logic            busy_q;
    logic            done_q;

    logic [14:0]     div_lim;
    logic            tick;
    logic            bit_end;
    logic            accept;
    logic            last_stop;

`ifdef TX_TWO_STOP_EN
    // Second stop bit: set after the first stop bit period completes.
    logic            stop_cnt_q;
    assign last_stop = stop_cnt_q;
`else
    assign last_stop = 1'b1;
`endif

    // Divider wrap value for the baud code latched with the current frame.
    always_comb begin
        div_lim = LIM_115200;
        case (baud_q)
            3'd0:    div_lim = LIM_300;
            3'd1:    div_lim = LIM_1200;
            3'd2:    div_lim = LIM_4800;
            3'd3:    div_lim = LIM_9600;
            3'd4:    div_lim = LIM_19200;
            3'd5:    div_lim = LIM_38400;
            3'd6:    div_lim = LIM_57600;
            default: div_lim = LIM_115200;
        endcase
    end

    // Baud tick generation and per-bit tick counting; bit_end marks the last tick of a bit.
    always_comb begin
        tick    = (div_q == div_lim);
        div_d   = tick ? 15'd0 : (div_q + 15'd1);
        bit_end = tick && (tick_q == TICK_LAST);
        if (bit_end) begin
            tick_d = '0;
        end else if (tick) begin
            tick_d = tick_q + 1'b1;
        end else begin
            tick_d = tick_q;
        end
        accept = (state_q == ST_IDLE) && Tx_EN && Tx_WR;
    end

    // Frame sequencer: counters, latched frame contents and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            baud_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TX_TWO_STOP_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            // Counters only run while a frame is in flight; IDLE holds them at zero
            // so that an accepted frame always starts on a clean bit boundary.
            if (state_q == ST_IDLE) begin
                div_q  <= '0;
                tick_q <= '0;
            end else begin
                div_q  <= div_d;
                tick_q <= tick_d;
            end

            case (state_q)
                ST_IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        shift_q   <= Tx_DATA;
                        parity_q  <= ^Tx_DATA;
                        baud_q    <= baud_select;
                        bit_idx_q <= '0;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= parity_q;
                            state_q <= ST_PARITY;
                        end else begin
                            // Shift so the next data bit is always at position 0.
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP;
`ifdef TX_TWO_STOP_EN
                        stop_cnt_q <= 1'b0;
`endif
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
`ifdef TX_TWO_STOP_EN
                        else begin
                            stop_cnt_q <= 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TxD       = txd_q;
    assign Tx_BUSY   = busy_q;
    assign Tx_DONE   = done_q;
    assign dbg_state = state_q;

endmodule
